// File: rtl/matrix_stream_loader_pkg.sv
// matrix_stream_loader_pkg: shared state enum and sizing helpers for the matrix stream loader
package matrix_stream_loader_pkg;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
  function automatic int elem_count(input int r, input int c);
    return r * c;
  endfunction
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if: element stream in, packed operand pair out (master = feeder/consumer, slave = loader)
interface matrix_stream_loader_if #(
  parameter int ROWS = 3,
  parameter int INNER = 2,
  parameter int COLS = 6,
  parameter int W = 8
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic [ROWS*INNER*W-1:0] mat_a;
  logic [INNER*COLS*W-1:0] mat_b;
  logic mat_valid;
  logic mat_ack;
  modport master (
    output flush, in_valid, in_data, mat_ack,
    input in_ready, mat_a, mat_b, mat_valid
  );
  modport slave (
    input flush, in_valid, in_data, mat_ack,
    output in_ready, mat_a, mat_b, mat_valid
  );
endinterface

// File: rtl/matrix_slice_writer.sv
// matrix_slice_writer: N-slice packed register, slice idx written MSB-first (idx 0 is the top slice)
module matrix_slice_writer #(
  parameter int N = 6,
  parameter int W = 8,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [CW-1:0] idx,
  input  logic [W-1:0] din,
  output logic [N*W-1:0] q
);
  logic [N*W-1:0] q_q, q_d;
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < N; i++) q_d[i*W +: W] = (we && idx == CW'(N - 1 - i)) ? din : q_q[i*W +: W];
  end
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: packs a serial element stream into A then B operands and holds them until acked
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int INNER = 2,
  parameter int COLS = 6,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  matrix_stream_loader_if.slave bus
);
  localparam int NA = elem_count(ROWS, INNER);
  localparam int NB = elem_count(INNER, COLS);
  localparam int CW = cnt_width(NA > NB ? NA : NB);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic beat, last, we_a, we_b;
  logic [NA*W-1:0] mat_a;
  logic [NB*W-1:0] mat_b;
  always_comb begin
    beat = bus.in_valid && bus.in_ready && !bus.flush;
    last = cnt_q == ((state_q == LOAD_A) ? CW'(NA - 1) : CW'(NB - 1));
    we_a = beat && state_q == LOAD_A;
    we_b = beat && state_q == LOAD_B;
    state_d = bus.flush ? LOAD_A :
              state_q == HOLD ? (bus.mat_ack ? LOAD_A : HOLD) :
              (beat && last) ? (state_q == LOAD_A ? LOAD_B : HOLD) : state_q;
    cnt_d = bus.flush ? '0 : beat ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? LOAD_A : state_d;
    cnt_q <= rst ? '0 : cnt_d;
  end
  matrix_slice_writer #(.N(NA), .W(W), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .we(we_a), .idx(cnt_q), .din(bus.in_data), .q(mat_a)
  );
  matrix_slice_writer #(.N(NB), .W(W), .CW(CW)) u_b (
    .clk(clk), .rst(rst), .we(we_b), .idx(cnt_q), .din(bus.in_data), .q(mat_b)
  );
  assign bus.mat_a = mat_a;
  assign bus.mat_b = mat_b;
  assign bus.in_ready = state_q != HOLD && !rst;
  assign bus.mat_valid = state_q == HOLD;
endmodule
